// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizing for the two-port FIFO write arbiter.
package fifo_wr_arb_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_WIDTHU   = 8;
    localparam int DEF_NUMWORDS = 256;
    localparam int DEF_MAXBURST = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_A = 2'd1,
        BURST_B = 2'd2,
        GAP     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; remembers the last port served (B after reset, so A wins first).
module rr_arb2 (
    input  logic Clock,
    input  logic Aclr_n,
    input  logic en,
    input  logic elig_a,
    input  logic elig_b,
    output logic pick_a,
    output logic pick_b
);

    logic last_b;

    assign pick_a = en & elig_a & (~elig_b | last_b);
    assign pick_b = en & elig_b & (~elig_a | ~last_b);

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n)     last_b <= 1'b1;
        else if (pick_a) last_b <= 1'b0;
        else if (pick_b) last_b <= 1'b1;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-granting write arbiter between two producers and one FIFO write port.
// Define FIFO_WR_ARB_PARITY_EN to add the FifoEDI even-parity output.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int WIDTHU   = DEF_WIDTHU,
    parameter int NUMWORDS = DEF_NUMWORDS,
    parameter int MAXBURST = DEF_MAXBURST,
    localparam int LW      = $clog2(MAXBURST + 1)
) (
    input  logic              Clock,
    input  logic              Aclr_n,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic [LW-1:0]     LenA,
    input  logic [LW-1:0]     LenB,
    input  logic              ValidA,
    input  logic              ValidB,
    input  logic [WIDTH-1:0]  DataA,
    input  logic [WIDTH-1:0]  DataB,
    output logic              GntA,
    output logic              GntB,
    output logic              AckA,
    output logic              AckB,
    output logic              FifoWrReq,
    output logic [WIDTH-1:0]  FifoData,
    input  logic              FifoFull,
    input  logic [WIDTHU-1:0] FifoUsedW,
`ifdef FIFO_WR_ARB_PARITY_EN
    output logic              FifoEDI,
`endif
    output logic              Busy
);

    arb_state_t       state, next;
    logic [LW-1:0]    cnt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTHU:0]  free;
    logic             elig_a, elig_b, pick_a, pick_b;

    // A burst is only admitted if the whole thing fits, so it can never hit FifoFull by itself.
    assign free   = FifoFull ? '0 : (WIDTHU+1)'(NUMWORDS) - {1'b0, FifoUsedW};
    assign elig_a = ReqA && (LenA != '0) && (32'(LenA) <= $unsigned(MAXBURST))
                         && (32'(LenA) <= 32'(free));
    assign elig_b = ReqB && (LenB != '0) && (32'(LenB) <= $unsigned(MAXBURST))
                         && (32'(LenB) <= 32'(free));

    // Gating on Aclr_n keeps Gnt low for the whole reset assertion.
    rr_arb2 u_rr (
        .Clock  (Clock),
        .Aclr_n (Aclr_n),
        .en     ((state == IDLE) & Aclr_n),
        .elig_a (elig_a),
        .elig_b (elig_b),
        .pick_a (pick_a),
        .pick_b (pick_b)
    );

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) state <= IDLE;
        else         state <= next;
    end

    always_comb begin
        next      = state;
        GntA      = 1'b0;
        GntB      = 1'b0;
        AckA      = 1'b0;
        AckB      = 1'b0;
        FifoWrReq = 1'b0;
        FifoData  = data_q;
        case (state)
            IDLE: begin
                GntA = pick_a;
                GntB = pick_b;
                if (pick_a)      next = BURST_A;
                else if (pick_b) next = BURST_B;
            end
            BURST_A: begin
                AckA      = ValidA & ~FifoFull;
                FifoWrReq = AckA;
                FifoData  = DataA;
                if (AckA && cnt == LW'(1)) next = GAP;
            end
            BURST_B: begin
                AckB      = ValidB & ~FifoFull;
                FifoWrReq = AckB;
                FifoData  = DataB;
                if (AckB && cnt == LW'(1)) next = GAP;
            end
            default: next = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n)           cnt <= '0;
        else if (pick_a)       cnt <= LenA;
        else if (pick_b)       cnt <= LenB;
        else if (AckA || AckB) cnt <= cnt - LW'(1);
    end

    // Holds the last word presented so FifoData stays put between bursts.
    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n)                                   data_q <= '0;
        else if (state == BURST_A || state == BURST_B) data_q <= FifoData;
    end

`ifdef FIFO_WR_ARB_PARITY_EN
    assign FifoEDI = ^FifoData;
`endif

endmodule
